uart_frame_scheduler: RTL and testbench
=======================================

Name: uart_frame_scheduler

Overview:
- Sequences one coincidence-count snapshot into a framed UART packet for the byte transmitter.
- Snapshots the nine 8-bit channel counts on a frame request. Emits header, sequence number, the nine counts and a checksum, one byte per tx_start/tx_done handshake.
- Sits between the coincidence counters and the send_byte transmitter. Replaces free-running output shuffling with deterministic, frame-aligned ordering.

Parameters:
- HDR0, 8'hA5, first sync byte
- HDR1, 8'h5A, second sync byte
- FRAME_GAP, 16, idle clk cycles after a frame's final tx_done before the next frame may start (0 = no gap)
- TX_TIMEOUT, 4096, max clk cycles spent waiting for tx_done before the frame is aborted

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_req  in  1  single-cycle request to send a new frame
- counts_A, counts_B, counts_BP, counts_AP, counts_AB, counts_ABP, counts_APB, counts_APBP, counts_ABBP  in  8 each  live channel counts
- tx_done  in  1  single-cycle pulse from transmitter: current byte fully sent
- err_clr  in  1  clears tx_error
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_done
- tx_start  out  1  single-cycle pulse: load tx_data
- byte_idx  out  4  index of current byte in frame, 0..12
- frame_busy  out  1  high from LOAD through GAP
- tx_error  out  1  sticky: a frame was aborted on timeout
- overrun_cnt  out  8  dropped requests, saturating at 255

Behaviour:
- Reset (async, rst_n low) values:
  - state=IDLE; tx_data=0, tx_start=0, byte_idx=0, frame_busy=0, tx_error=0, overrun_cnt=0
  - seq=0, pending=0, snapshot registers=0
- Frame: 13 bytes, in this order:
  - idx0=HDR0, idx1=HDR1, idx2=seq
  - idx3..11 = A, B, BP, AP, AB, ABP, APB, APBP, ABBP
  - idx12 = checksum = (seq + sum of the nine counts) mod 256
- States:
  - IDLE: on frame_req or pending -> LOAD; pending cleared.
  - LOAD: one cycle. Captures all nine counts into snapshot registers. Computes checksum from the snapshot. byte_idx=0 -> SEND.
  - SEND: one cycle. tx_start=1, tx_data=byte[byte_idx] -> WAIT.
  - WAIT: waits for tx_done.
    - On tx_done with byte_idx<12: byte_idx+1 -> SEND.
    - On tx_done with byte_idx=12: seq+1 (wraps 255->0) -> GAP.
    - Timeout counter reaches TX_TIMEOUT: tx_error=1, seq unchanged, byte_idx=0 -> GAP.
  - GAP: counts FRAME_GAP cycles -> IDLE. With FRAME_GAP=0, GAP lasts one cycle.
- Latency:
  - frame_req sampled high in IDLE at edge k -> LOAD during cycle k..k+1 -> tx_start high in cycle following edge k+1 (2 clk cycles).
  - tx_done at edge m -> next tx_start in cycle following edge m.
- Live count changes after LOAD do not affect the frame in flight.
- frame_req while frame_busy:
  - pending=0 -> pending=1.
  - pending=1 -> overrun_cnt+1, saturating at 255.
  - Request in the same cycle GAP exits counts as pending, not dropped.
- tx_done outside WAIT is ignored.
- Timeout counter resets on every SEND.
- err_clr clears tx_error. A timeout abort in the same cycle as err_clr wins (tx_error=1).
- tx_start is never asserted outside SEND and never on consecutive cycles.
- Reset mid-frame: immediate return to reset values. Partially sent frame abandoned, no completion.

Test Plan:
- Basic frame: counts 1..9 (A=1 … ABBP=9), seq=0, frame_req, tx_done 10 cycles after each tx_start -> tx_data sequence A5,5A,00,01..09,2D. byte_idx 0..12. Then seq=1, frame_busy drops FRAME_GAP+1 cycles after last tx_done.
- Checksum wrap: all counts=FF, seq driven to 03 by three prior frames -> checksum byte FA.
- Snapshot stability: change counts_A from 10 to 20 right after LOAD -> idx3 byte = 0A. Next frame sends 14.
- Overrun: three frame_req pulses during one frame -> overrun_cnt=2. Exactly one further frame follows. 258 extra requests -> overrun_cnt saturates at FF.
- Timeout: withhold tx_done after idx5 with TX_TIMEOUT=4096 -> tx_error=1 after 4096 cycles, seq unchanged, next frame restarts at A5. err_clr pulse -> tx_error=0.
- Async reset mid-WAIT at idx7: assert rst_n low between edges -> all outputs zero immediately, no tx_start until a new frame_req after release.

Source files
------------

// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: snapshots nine channel counts and sends them as a 13-byte
// framed packet (sync, sequence, counts, checksum) over a tx_start/tx_done handshake.
module uart_frame_scheduler #(
    parameter logic [7:0] HDR0       = 8'hA5,
    parameter logic [7:0] HDR1       = 8'h5A,
    parameter int         FRAME_GAP  = 16,
    parameter int         TX_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_req,
    input  logic [7:0] counts_A,
    input  logic [7:0] counts_B,
    input  logic [7:0] counts_BP,
    input  logic [7:0] counts_AP,
    input  logic [7:0] counts_AB,
    input  logic [7:0] counts_ABP,
    input  logic [7:0] counts_APB,
    input  logic [7:0] counts_APBP,
    input  logic [7:0] counts_ABBP,
    input  logic       tx_done,
    input  logic       err_clr,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [3:0] byte_idx,
    output logic       frame_busy,
    output logic       tx_error,
    output logic [7:0] overrun_cnt
);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, SEND = 3'd2, WAIT = 3'd3, GAP = 3'd4;
    localparam int TW = $clog2(TX_TIMEOUT + 1);
    localparam int GN = (FRAME_GAP > 0) ? FRAME_GAP : 1;
    localparam int GW = $clog2(GN + 1);

    logic [2:0]    state;
    logic [7:0]    seq, csum;
    logic [7:0]    snap [9];
    logic          pending, timeout;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic [3:0]    nidx, sidx;
    logic [7:0]    nbyte;

    // Byte that the next SEND will present, selected by the upcoming index.
    always_comb begin
        nidx    = (state == LOAD) ? 4'd0 : byte_idx + 4'd1;
        sidx    = nidx - 4'd3;
        nbyte   = (nidx == 4'd0)  ? HDR0 :
                  (nidx == 4'd1)  ? HDR1 :
                  (nidx == 4'd2)  ? seq  :
                  (nidx == 4'd12) ? csum : snap[sidx];
        timeout = (state == WAIT) && !tx_done && (tcnt == TW'(TX_TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            byte_idx    <= '0;
            frame_busy  <= 1'b0;
            tx_error    <= 1'b0;
            overrun_cnt <= '0;
            seq         <= '0;
            csum        <= '0;
            pending     <= 1'b0;
            snap        <= '{default: '0};
            tcnt        <= '0;
            gcnt        <= '0;
        end else begin
            tx_start <= 1'b0;
            tx_error <= timeout || (tx_error && !err_clr);
            if (frame_busy && frame_req) begin
                if (!pending)
                    pending <= 1'b1;
                else if (overrun_cnt != 8'hFF)
                    overrun_cnt <= overrun_cnt + 8'd1;
            end
            case (state)
                IDLE: if (frame_req || pending) begin
                    state      <= LOAD;
                    pending    <= 1'b0;
                    frame_busy <= 1'b1;
                end
                LOAD: begin
                    snap     <= '{counts_A, counts_B, counts_BP, counts_AP, counts_AB,
                                  counts_ABP, counts_APB, counts_APBP, counts_ABBP};
                    csum     <= seq + counts_A + counts_B + counts_BP + counts_AP + counts_AB
                                + counts_ABP + counts_APB + counts_APBP + counts_ABBP;
                    byte_idx <= 4'd0;
                    tx_data  <= nbyte;
                    tx_start <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: if (tx_done) begin
                    if (byte_idx == 4'd12) begin
                        seq   <= seq + 8'd1;
                        gcnt  <= '0;
                        state <= GAP;
                    end else begin
                        byte_idx <= nidx;
                        tx_data  <= nbyte;
                        tx_start <= 1'b1;
                        state    <= SEND;
                    end
                end else if (timeout) begin
                    byte_idx <= 4'd0;
                    gcnt     <= '0;
                    state    <= GAP;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                GAP: if (gcnt == GW'(GN - 1)) begin
                    state      <= IDLE;
                    frame_busy <= 1'b0;
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb_uart_frame_scheduler: randomized frame traffic checked against a frame-level
// model (expected byte list, sequence and overrun bookkeeping).
module tb_uart_frame_scheduler;
    logic       clk = 1'b0, rst_n = 1'b0, frame_req = 1'b0, tx_done = 1'b0, err_clr = 1'b0;
    logic [7:0] cnt [9];
    logic [7:0] tx_data, overrun_cnt;
    logic       tx_start, frame_busy, tx_error;
    logic [3:0] byte_idx;

    int         checks = 0, errors = 0;
    logic [7:0] m_seq = 8'd0;
    int         m_ovr = 0;
    bit         m_pend = 1'b0;

    uart_frame_scheduler dut (
        .clk(clk), .rst_n(rst_n), .frame_req(frame_req),
        .counts_A(cnt[0]), .counts_B(cnt[1]), .counts_BP(cnt[2]), .counts_AP(cnt[3]),
        .counts_AB(cnt[4]), .counts_ABP(cnt[5]), .counts_APB(cnt[6]), .counts_APBP(cnt[7]),
        .counts_ABBP(cnt[8]), .tx_done(tx_done), .err_clr(err_clr), .tx_data(tx_data),
        .tx_start(tx_start), .byte_idx(byte_idx), .frame_busy(frame_busy),
        .tx_error(tx_error), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    function automatic void expect_frame(input logic [7:0] s, output logic [7:0] e [13]);
        int sum;
        sum  = int'(s);
        e[0] = 8'hA5;
        e[1] = 8'h5A;
        e[2] = s;
        for (int j = 0; j < 9; j++) begin
            e[3 + j] = cnt[j];
            sum += int'(cnt[j]);
        end
        e[12] = 8'(sum % 256);
    endfunction

    task automatic randomize_counts();
        for (int j = 0; j < 9; j++) cnt[j] = 8'($urandom);
    endtask

    task automatic req();
        int w;
        w = 0;
        while (frame_busy && w < 300) begin @(negedge clk); w++; end
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
    endtask

    // Handshakes the first n bytes of a frame, recording each byte and its index.
    task automatic collect(input int n, input int dly, output logic [7:0] b [13],
                           output logic [3:0] ix [13], output bit ok);
        int w;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!tx_start && w < 200) begin @(negedge clk); w++; end
            if (!tx_start) begin ok = 1'b0; return; end
            b[i]  = tx_data;
            ix[i] = byte_idx;
            repeat (dly) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_data, tx_start, byte_idx, frame_busy, tx_error, overrun_cnt} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h %b %0d %b %b %h required all zero",
                     tx_data, tx_start, byte_idx, frame_busy, tx_error, overrun_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [7:0] b [13], e [13];
        logic [3:0] ix [13];
        bit ok;
        for (int j = 0; j < 9; j++) cnt[j] = 8'(j + 1);
        expect_frame(m_seq, e);
        req();
        checks++;
        if ({tx_start, frame_busy} !== 2'b01) begin
            errors++;
            $display("FAIL basic_load_cycle got start=%b busy=%b required start=0 busy=1", tx_start, frame_busy);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency got tx_start=%b required 1", tx_start);
        end
        collect(13, 10, b, ix, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_handshake got no tx_start required 13 bytes"); end
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (b[i] !== e[i] || ix[i] !== 4'(i)) begin
                errors++;
                $display("FAIL basic_byte%0d got %h idx %0d required %h idx %0d", i, b[i], ix[i], e[i], i);
            end
        end
        m_seq++;
        repeat (15) @(negedge clk);
        checks++;
        if (frame_busy !== 1'b1) begin errors++; $display("FAIL basic_gap_busy got %b required 1", frame_busy); end
        @(negedge clk);
        checks++;
        if (frame_busy !== 1'b0) begin errors++; $display("FAIL basic_gap_end got %b required 0", frame_busy); end
    endtask

    task automatic test_random_frames(input int nf, input bit all_ff);
        logic [7:0] b [13], e [13];
        logic [3:0] ix [13];
        bit ok;
        for (int f = 0; f < nf; f++) begin
            if (all_ff) for (int j = 0; j < 9; j++) cnt[j] = 8'hFF;
            else randomize_counts();
            expect_frame(m_seq, e);
            req();
            collect(13, 1 + int'($urandom_range(4)), b, ix, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL random_handshake frame %0d got no tx_start", f); end
            for (int i = 0; i < 13; i++) begin
                checks++;
                if (b[i] !== e[i]) begin
                    errors++;
                    $display("FAIL %s_byte%0d got %h required %h", all_ff ? "wrap" : "random", i, b[i], e[i]);
                end
            end
            m_seq++;
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] b [13], e [13];
        logic [3:0] ix [13];
        bit ok;
        randomize_counts();
        cnt[0] = 8'h0A;
        expect_frame(m_seq, e);
        req();
        @(negedge clk);
        cnt[0] = 8'h14;
        collect(13, 2, b, ix, ok);
        checks++;
        if (!ok || b[3] !== 8'h0A || b[12] !== e[12]) begin
            errors++;
            $display("FAIL snapshot_hold got A=%h sum=%h required A=0a sum=%h", b[3], b[12], e[12]);
        end
        m_seq++;
        expect_frame(m_seq, e);
        req();
        collect(13, 2, b, ix, ok);
        checks++;
        if (!ok || b[3] !== 8'h14 || b[12] !== e[12]) begin
            errors++;
            $display("FAIL snapshot_next got A=%h sum=%h required A=14 sum=%h", b[3], b[12], e[12]);
        end
        m_seq++;
    endtask

    task automatic overrun_frame(input int pulses, input int dly);
        logic [7:0] b [13], e [13];
        logic [3:0] ix [13];
        bit ok;
        randomize_counts();
        expect_frame(m_seq, e);
        req();
        fork
            collect(13, dly, b, ix, ok);
            for (int p = 0; p < pulses; p++) begin
                frame_req = 1'b1;
                @(negedge clk);
                frame_req = 1'b0;
                @(negedge clk);
                if (!m_pend) m_pend = 1'b1;
                else if (m_ovr < 255) m_ovr++;
            end
        join
        checks++;
        if (!ok || b[2] !== e[2] || b[12] !== e[12]) begin
            errors++;
            $display("FAIL overrun_frame got seq=%h sum=%h required seq=%h sum=%h", b[2], b[12], e[2], e[12]);
        end
        m_seq++;
        checks++;
        if (overrun_cnt !== 8'(m_ovr)) begin
            errors++;
            $display("FAIL overrun_count got %0d required %0d", overrun_cnt, m_ovr);
        end
        // The pending request produces exactly one more frame without a new request.
        expect_frame(m_seq, e);
        collect(13, 2, b, ix, ok);
        m_pend = 1'b0;
        checks++;
        if (!ok || b[0] !== 8'hA5 || b[2] !== e[2] || b[12] !== e[12]) begin
            errors++;
            $display("FAIL overrun_pending got ok=%b seq=%h sum=%h required seq=%h sum=%h", ok, b[2], b[12], e[2], e[12]);
        end
        m_seq++;
    endtask

    task automatic test_overrun();
        int starts;
        overrun_frame(3, 4);
        starts = 0;
        repeat (60) begin @(negedge clk); if (tx_start) starts++; end
        checks++;
        if (starts !== 0 || frame_busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_single_followup got %0d extra starts busy=%b required 0", starts, frame_busy);
        end
        overrun_frame(258, 45);
        checks++;
        if (overrun_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL overrun_saturate got %h required ff", overrun_cnt);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b [13], e [13];
        logic [3:0] ix [13];
        bit ok;
        int w;
        randomize_counts();
        expect_frame(m_seq, e);
        req();
        collect(5, 2, b, ix, ok);
        w = 0;
        while (!tx_start && w < 200) begin @(negedge clk); w++; end
        checks++;
        if (!ok || tx_start !== 1'b1 || byte_idx !== 4'd5 || tx_data !== e[5]) begin
            errors++;
            $display("FAIL timeout_idx5 got idx=%0d data=%h required idx=5 data=%h", byte_idx, tx_data, e[5]);
        end
        w = 0;
        while (!tx_error && w < 5000) begin @(negedge clk); w++; end
        checks++;
        if (w < 4094 || w > 4100) begin
            errors++;
            $display("FAIL timeout_delay got %0d cycles required about 4096", w);
        end
        checks++;
        if (byte_idx !== 4'd0 || frame_busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort got idx=%0d busy=%b required idx=0 busy=1", byte_idx, frame_busy);
        end
        randomize_counts();
        expect_frame(m_seq, e);
        req();
        collect(13, 1, b, ix, ok);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (!ok || b[i] !== e[i]) begin
                errors++;
                $display("FAIL timeout_restart_byte%0d got %h required %h", i, b[i], e[i]);
            end
        end
        m_seq++;
        checks++;
        if (tx_error !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b required 1", tx_error); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (tx_error !== 1'b0) begin errors++; $display("FAIL timeout_err_clr got %b required 0", tx_error); end
    endtask

    task automatic test_async_reset();
        logic [7:0] b [13], e [13];
        logic [3:0] ix [13];
        bit ok;
        int w, starts;
        randomize_counts();
        req();
        collect(7, 1, b, ix, ok);
        w = 0;
        while (!tx_start && w < 200) begin @(negedge clk); w++; end
        checks++;
        if (!ok || byte_idx !== 4'd7) begin
            errors++;
            $display("FAIL reset_reach_idx7 got idx=%0d required 7", byte_idx);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_data, tx_start, byte_idx, frame_busy, tx_error, overrun_cnt} !== 23'd0) begin
            errors++;
            $display("FAIL reset_async got %h %b %0d %b %b %h required all zero",
                     tx_data, tx_start, byte_idx, frame_busy, tx_error, overrun_cnt);
        end
        starts = 0;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (10) begin @(negedge clk); if (tx_start) starts++; end
        rst_n = 1'b1;
        repeat (30) begin @(negedge clk); if (tx_start || frame_busy) starts++; end
        checks++;
        if (starts !== 0) begin
            errors++;
            $display("FAIL reset_quiet got %0d active cycles required 0", starts);
        end
        m_seq  = 8'd0;
        m_ovr  = 0;
        m_pend = 1'b0;
        randomize_counts();
        expect_frame(m_seq, e);
        req();
        collect(13, 3, b, ix, ok);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (!ok || b[i] !== e[i]) begin
                errors++;
                $display("FAIL reset_new_frame_byte%0d got %h required %h", i, b[i], e[i]);
            end
        end
    endtask

    initial begin
        for (int j = 0; j < 9; j++) cnt[j] = 8'd0;
        test_reset();
        test_basic_frame();
        test_random_frames(2, 1'b0);
        test_random_frames(1, 1'b1);
        test_random_frames(3, 1'b0);
        test_snapshot();
        test_overrun();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
